// File: rtl/irq_sequencer_ctrl_if.sv
// Bus between the program sequencer (master) and the interrupt/return controller (slave).
// Sequencer-side inputs are sampled at the controller clock; every controller output is a registered decode.
interface irq_sequencer_ctrl_if #(
    parameter int NUM_IRQ     = 4,
    parameter int STACK_DEPTH = 4
);
    localparam int AW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam int DW = $clog2(STACK_DEPTH + 1);

    logic [NUM_IRQ-1:0] irq;
    logic               mask_wr;
    logic [NUM_IRQ-1:0] mask_in;
    logic [7:0]         pc;
    logic               reti;
    logic               seq_jmp;
    logic               irq_jmp;
    logic [3:0]         irq_jmp_addr;
    logic               ret_jmp;
    logic [7:0]         ret_addr;
    logic [NUM_IRQ-1:0] irq_ack;
    logic               in_isr;
    logic [AW-1:0]      active_irq;
    logic [DW-1:0]      nest_depth;
    logic               stack_full;
    logic               underflow;
    logic [1:0]         dbg_state;

    modport master (
        output irq, mask_wr, mask_in, pc, reti, seq_jmp,
        input  irq_jmp, irq_jmp_addr, ret_jmp, ret_addr, irq_ack,
        input  in_isr, active_irq, nest_depth, stack_full, underflow, dbg_state
    );

    modport slave (
        input  irq, mask_wr, mask_in, pc, reti, seq_jmp,
        output irq_jmp, irq_jmp_addr, ret_jmp, ret_addr, irq_ack,
        output in_isr, active_irq, nest_depth, stack_full, underflow, dbg_state
    );
endinterface

// File: rtl/irq_sequencer_ctrl.sv
// Prioritised, nestable interrupt entry and RETI return controller for the 8-bit program sequencer.
// Return addresses live in a shift-register stack so the top entry is always slot 0.
module irq_sequencer_ctrl #(
    parameter int         NUM_IRQ     = 4,
    parameter int         STACK_DEPTH = 4,
    parameter logic [3:0] VEC_BASE    = 4'h8
) (
    input  logic               clk,
    input  logic               sync_reset,
    irq_sequencer_ctrl_if.slave bus
);
    localparam int AW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam int DW = $clog2(STACK_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_ENTER = 2'd1,
        ST_EXIT  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [NUM_IRQ-1:0] r_irq_prev;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_mask;
    logic [NUM_IRQ-1:0] w_edge;
    logic [NUM_IRQ-1:0] w_clr;
    logic [AW-1:0]      r_win;
    logic [AW-1:0]      r_active;
    logic [AW-1:0]      w_win;
    logic               w_found;
    logic               w_set_uf;
    logic               w_in_isr;
    logic               w_full;
    logic [DW-1:0]      r_depth;
    logic               r_uf;
    logic [7:0]         r_stk_addr [STACK_DEPTH];
    logic [AW-1:0]      r_stk_irq  [STACK_DEPTH];

    assign w_edge   = bus.irq & ~r_irq_prev;
    assign w_in_isr = (r_depth != '0);
    assign w_full   = (r_depth == DW'(STACK_DEPTH));

    // Lowest eligible index wins; inside an ISR only strictly higher priority may preempt.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (r_pending[i] && r_mask[i] && (!w_in_isr || (AW'(i) < r_active))) begin
                w_found = 1'b1;
                w_win   = AW'(i);
            end
        end
    end

    always_comb begin
        w_clr = '0;
        if (r_state == ST_ENTER) begin
            w_clr[r_win] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // reti is only honoured in RUN and beats a simultaneous request, which stays pending.
    always_comb begin
        w_state_nxt = ST_RUN;
        w_set_uf    = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (bus.reti) begin
                    if (w_in_isr) begin
                        w_state_nxt = ST_EXIT;
                    end else begin
                        w_set_uf = 1'b1;
                    end
                end else if (w_found && !bus.seq_jmp && !w_full) begin
                    w_state_nxt = ST_ENTER;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            r_irq_prev <= '0;
            r_pending  <= '0;
            r_mask     <= '0;
            r_win      <= '0;
            r_active   <= '0;
            r_depth    <= '0;
            r_uf       <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                r_stk_addr[i] <= '0;
                r_stk_irq[i]  <= '0;
            end
        end else begin
            r_irq_prev <= bus.irq;
            r_pending  <= (r_pending | w_edge) & ~w_clr;
            if (bus.mask_wr) begin
                r_mask <= bus.mask_in;
            end
            if (w_set_uf) begin
                r_uf <= 1'b1;
            end
            if ((r_state == ST_RUN) && (w_state_nxt == ST_ENTER)) begin
                r_win <= w_win;
            end
            case (r_state)
                ST_ENTER: begin
                    for (int i = STACK_DEPTH - 1; i > 0; i--) begin
                        r_stk_addr[i] <= r_stk_addr[i-1];
                        r_stk_irq[i]  <= r_stk_irq[i-1];
                    end
                    r_stk_addr[0] <= bus.pc + 8'd1;
                    r_stk_irq[0]  <= r_active;
                    r_active      <= r_win;
                    r_depth       <= r_depth + DW'(1);
                end
                ST_EXIT: begin
                    for (int i = 0; i < STACK_DEPTH - 1; i++) begin
                        r_stk_addr[i] <= r_stk_addr[i+1];
                        r_stk_irq[i]  <= r_stk_irq[i+1];
                    end
                    r_active <= r_stk_irq[0];
                    r_depth  <= r_depth - DW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.irq_jmp      = (r_state == ST_ENTER);
    assign bus.irq_jmp_addr = (r_state == ST_ENTER) ? (VEC_BASE + 4'(r_win)) : 4'h0;
    assign bus.irq_ack      = w_clr;
    assign bus.ret_jmp      = (r_state == ST_EXIT);
    assign bus.ret_addr     = (r_state == ST_EXIT) ? r_stk_addr[0] : 8'h00;
    assign bus.in_isr       = w_in_isr;
    assign bus.active_irq   = r_active;
    assign bus.nest_depth   = r_depth;
    assign bus.stack_full   = w_full;
    assign bus.underflow    = r_uf;
    assign bus.dbg_state    = r_state;
endmodule

// File: tb/tb_irq_sequencer_ctrl.sv
// Bench for irq_sequencer_ctrl: directed scenarios plus a randomized run against a queue-based model.
// A second instance with a two-entry stack covers the stack-full blocking case.
module tb_irq_sequencer_ctrl;
    logic clk = 1'b0;
    logic sync_reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    irq_sequencer_ctrl_if #(.NUM_IRQ(4), .STACK_DEPTH(4)) b1 ();
    irq_sequencer_ctrl_if #(.NUM_IRQ(4), .STACK_DEPTH(2)) b2 ();

    irq_sequencer_ctrl #(.NUM_IRQ(4), .STACK_DEPTH(4), .VEC_BASE(4'h8)) u_dut1 (
        .clk(clk), .sync_reset(sync_reset), .bus(b1)
    );
    irq_sequencer_ctrl #(.NUM_IRQ(4), .STACK_DEPTH(2), .VEC_BASE(4'h8)) u_dut2 (
        .clk(clk), .sync_reset(sync_reset), .bus(b2)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        b1.irq = '0; b1.mask_wr = 1'b0; b1.mask_in = '0; b1.pc = '0; b1.reti = 1'b0; b1.seq_jmp = 1'b0;
        b2.irq = '0; b2.mask_wr = 1'b0; b2.mask_in = '0; b2.pc = '0; b2.reti = 1'b0; b2.seq_jmp = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        sync_reset = 1'b1;
        repeat (2) tick();
        sync_reset = 1'b0;
        tick();
    endtask

    function automatic logic [25:0] outs1();
        return {b1.irq_jmp, b1.irq_jmp_addr, b1.ret_jmp, b1.ret_addr, b1.irq_ack,
                b1.in_isr, b1.active_irq, b1.nest_depth, b1.stack_full, b1.underflow};
    endfunction

    task automatic write_mask(input bit sel, input logic [3:0] m);
        if (sel) begin b2.mask_wr = 1'b1; b2.mask_in = m; end
        else     begin b1.mask_wr = 1'b1; b1.mask_in = m; end
        tick();
        b1.mask_wr = 1'b0;
        b2.mask_wr = 1'b0;
    endtask

    task automatic wait_jmp(input bit sel, input int max_cyc, output int n);
        n = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            tick();
            if ((sel ? b2.irq_jmp : b1.irq_jmp) === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        sync_reset = 1'b1;
        tick();
        n_tests++;
        if (outs1() !== 26'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h, required 0", outs1());
        end
        n_tests++;
        if ({b2.nest_depth, b2.stack_full, b2.dbg_state} !== 5'd0) begin
            n_fail++; $display("FAIL reset_dut2: got %h, required 0", {b2.nest_depth, b2.stack_full, b2.dbg_state});
        end
        sync_reset = 1'b0;
        repeat (2) tick();
        n_tests++;
        if (outs1() !== 26'd0) begin
            n_fail++; $display("FAIL reset_idle: got %h, required 0", outs1());
        end
    endtask

    task automatic test_single();
        int n;
        do_reset();
        write_mask(0, 4'b0001);
        b1.pc = 8'h23;
        b1.irq[0] = 1'b1;
        wait_jmp(0, 6, n);
        n_tests++;
        if (n !== 2) begin n_fail++; $display("FAIL single_latency: got %0d, required 2", n); end
        n_tests++;
        if ({b1.irq_jmp_addr, b1.irq_ack} !== {4'h8, 4'b0001}) begin
            n_fail++; $display("FAIL single_vector: got addr=%h ack=%b, required 8/0001", b1.irq_jmp_addr, b1.irq_ack);
        end
        tick();
        b1.irq = '0;
        n_tests++;
        if ({b1.nest_depth, b1.in_isr, b1.irq_jmp} !== {3'd1, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL single_depth: got depth=%0d in_isr=%b jmp=%b, required 1/1/0", b1.nest_depth, b1.in_isr, b1.irq_jmp);
        end
        tick();
        b1.reti = 1'b1;
        tick();
        b1.reti = 1'b0;
        n_tests++;
        if ({b1.ret_jmp, b1.ret_addr, b1.irq_jmp} !== {1'b1, 8'h24, 1'b0}) begin
            n_fail++; $display("FAIL single_return: got ret=%b addr=%h, required 1/24", b1.ret_jmp, b1.ret_addr);
        end
        tick();
        n_tests++;
        if ({b1.nest_depth, b1.ret_jmp, b1.in_isr} !== 5'd0) begin
            n_fail++; $display("FAIL single_after_ret: got depth=%0d ret=%b, required 0/0", b1.nest_depth, b1.ret_jmp);
        end
    endtask

    task automatic test_priority_nesting();
        int n;
        do_reset();
        write_mask(0, 4'hF);
        b1.pc = 8'h40;
        b1.irq[2] = 1'b1;
        wait_jmp(0, 6, n);
        n_tests++;
        if (n !== 2 || b1.irq_jmp_addr !== 4'hA) begin
            n_fail++; $display("FAIL nest_first: got n=%0d addr=%h, required 2/A", n, b1.irq_jmp_addr);
        end
        tick();
        b1.irq = '0;
        n_tests++;
        if ({b1.active_irq, b1.nest_depth} !== {2'd2, 3'd1}) begin
            n_fail++; $display("FAIL nest_active2: got active=%0d depth=%0d, required 2/1", b1.active_irq, b1.nest_depth);
        end
        b1.irq[3] = 1'b1;
        wait_jmp(0, 5, n);
        n_tests++;
        if (n !== -1) begin n_fail++; $display("FAIL nest_low_blocked: got entry at %0d, required none", n); end
        b1.irq = '0;
        b1.pc = 8'h50;
        b1.irq[0] = 1'b1;
        wait_jmp(0, 6, n);
        n_tests++;
        if (n !== 2 || b1.irq_jmp_addr !== 4'h8) begin
            n_fail++; $display("FAIL nest_preempt: got n=%0d addr=%h, required 2/8", n, b1.irq_jmp_addr);
        end
        tick();
        b1.irq = '0;
        n_tests++;
        if ({b1.active_irq, b1.nest_depth} !== {2'd0, 3'd2}) begin
            n_fail++; $display("FAIL nest_depth2: got active=%0d depth=%0d, required 0/2", b1.active_irq, b1.nest_depth);
        end
        b1.reti = 1'b1;
        tick();
        b1.reti = 1'b0;
        n_tests++;
        if ({b1.ret_jmp, b1.ret_addr} !== {1'b1, 8'h51}) begin
            n_fail++; $display("FAIL nest_ret1: got ret=%b addr=%h, required 1/51", b1.ret_jmp, b1.ret_addr);
        end
        tick();
        n_tests++;
        if ({b1.active_irq, b1.nest_depth} !== {2'd2, 3'd1}) begin
            n_fail++; $display("FAIL nest_restore: got active=%0d depth=%0d, required 2/1", b1.active_irq, b1.nest_depth);
        end
        b1.reti = 1'b1;
        tick();
        b1.reti = 1'b0;
        n_tests++;
        if ({b1.ret_jmp, b1.ret_addr} !== {1'b1, 8'h41}) begin
            n_fail++; $display("FAIL nest_ret2: got ret=%b addr=%h, required 1/41", b1.ret_jmp, b1.ret_addr);
        end
        wait_jmp(0, 6, n);
        n_tests++;
        if (n !== 2 || b1.irq_jmp_addr !== 4'hB || b1.irq_ack !== 4'b1000) begin
            n_fail++; $display("FAIL nest_deferred3: got n=%0d addr=%h ack=%b, required 2/B/1000", n, b1.irq_jmp_addr, b1.irq_ack);
        end
    endtask

    task automatic test_blocking();
        int n;
        bit seen;
        do_reset();
        write_mask(0, 4'b0010);
        b1.pc = 8'h10;
        b1.seq_jmp = 1'b1;
        b1.irq[1] = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            tick();
            if (b1.irq_jmp === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL block_seqjmp: got irq_jmp=1, required 0"); end
        b1.seq_jmp = 1'b0;
        wait_jmp(0, 4, n);
        n_tests++;
        if (n !== 1 || b1.irq_jmp_addr !== 4'h9) begin
            n_fail++; $display("FAIL block_release: got n=%0d addr=%h, required 1/9", n, b1.irq_jmp_addr);
        end
        tick();
        b1.irq = '0;
        b1.reti = 1'b1;
        tick();
        b1.reti = 1'b0;
        tick();
        write_mask(0, 4'b0000);
        b1.irq[1] = 1'b1;
        wait_jmp(0, 5, n);
        n_tests++;
        if (n !== -1) begin n_fail++; $display("FAIL block_masked: got entry at %0d, required none", n); end
        write_mask(0, 4'b0010);
        wait_jmp(0, 4, n);
        n_tests++;
        if (n !== 1 || b1.irq_jmp_addr !== 4'h9) begin
            n_fail++; $display("FAIL block_unmask: got n=%0d addr=%h, required 1/9", n, b1.irq_jmp_addr);
        end
        tick();
        b1.irq = '0;
    endtask

    task automatic test_collision_underflow();
        int n;
        do_reset();
        write_mask(0, 4'hF);
        b1.pc = 8'h30;
        b1.irq[2] = 1'b1;
        wait_jmp(0, 6, n);
        tick();
        b1.irq = 4'b0010;
        tick();
        b1.reti = 1'b1;
        tick();
        b1.reti = 1'b0;
        n_tests++;
        if ({b1.ret_jmp, b1.irq_jmp, b1.ret_addr} !== {1'b1, 1'b0, 8'h31}) begin
            n_fail++; $display("FAIL collide_exit_first: got ret=%b jmp=%b addr=%h, required 1/0/31", b1.ret_jmp, b1.irq_jmp, b1.ret_addr);
        end
        wait_jmp(0, 6, n);
        n_tests++;
        if (n !== 2 || b1.irq_jmp_addr !== 4'h9) begin
            n_fail++; $display("FAIL collide_enter_after: got n=%0d addr=%h, required 2/9", n, b1.irq_jmp_addr);
        end
        tick();
        b1.irq = '0;
        b1.reti = 1'b1;
        tick();
        b1.reti = 1'b0;
        tick();
        b1.reti = 1'b1;
        tick();
        b1.reti = 1'b0;
        n_tests++;
        if ({b1.ret_jmp, b1.underflow, b1.nest_depth} !== {1'b0, 1'b1, 3'd0}) begin
            n_fail++; $display("FAIL underflow_set: got ret=%b uf=%b depth=%0d, required 0/1/0", b1.ret_jmp, b1.underflow, b1.nest_depth);
        end
        repeat (3) tick();
        n_tests++;
        if (b1.underflow !== 1'b1) begin n_fail++; $display("FAIL underflow_sticky: got %b, required 1", b1.underflow); end
    endtask

    task automatic test_stack_full();
        int n;
        do_reset();
        write_mask(1, 4'hF);
        b2.pc = 8'h60;
        b2.irq = 4'b1000;
        wait_jmp(1, 6, n);
        tick();
        b2.irq = 4'b0100;
        wait_jmp(1, 6, n);
        n_tests++;
        if (n !== 2 || b2.irq_jmp_addr !== 4'hA) begin
            n_fail++; $display("FAIL full_second_entry: got n=%0d addr=%h, required 2/A", n, b2.irq_jmp_addr);
        end
        tick();
        b2.irq = '0;
        n_tests++;
        if ({b2.stack_full, b2.nest_depth, b2.active_irq} !== {1'b1, 2'd2, 2'd2}) begin
            n_fail++; $display("FAIL full_flag: got full=%b depth=%0d active=%0d, required 1/2/2", b2.stack_full, b2.nest_depth, b2.active_irq);
        end
        b2.irq = 4'b0010;
        wait_jmp(1, 5, n);
        n_tests++;
        if (n !== -1 || b2.nest_depth !== 2'd2) begin
            n_fail++; $display("FAIL full_blocks: got n=%0d depth=%0d, required none/2", n, b2.nest_depth);
        end
        b2.reti = 1'b1;
        tick();
        b2.reti = 1'b0;
        n_tests++;
        if ({b2.ret_jmp, b2.ret_addr} !== {1'b1, 8'h61}) begin
            n_fail++; $display("FAIL full_ret: got ret=%b addr=%h, required 1/61", b2.ret_jmp, b2.ret_addr);
        end
        wait_jmp(1, 6, n);
        n_tests++;
        if (n !== 2 || b2.irq_jmp_addr !== 4'h9) begin
            n_fail++; $display("FAIL full_enter_after: got n=%0d addr=%h, required 2/9", n, b2.irq_jmp_addr);
        end
        tick();
        b2.irq = '0;
        n_tests++;
        if ({b2.stack_full, b2.nest_depth, b2.active_irq} !== {1'b1, 2'd2, 2'd1}) begin
            n_fail++; $display("FAIL full_refill: got full=%b depth=%0d active=%0d, required 1/2/1", b2.stack_full, b2.nest_depth, b2.active_irq);
        end
    endtask

    task automatic test_random();
        logic [3:0] m_pend, m_prev, m_mask, tog, new_irq, edges;
        logic [7:0] m_ret_q[$];
        int         m_irq_q[$];
        int         m_act, m_win, shown, sz, act_i;
        logic       m_uf;
        logic [25:0] exp_v;
        do_reset();
        m_pend = '0; m_prev = '0; m_mask = '0; m_act = 0; m_win = 0; m_uf = 1'b0; shown = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            sz    = m_ret_q.size();
            act_i = (sz > 0) ? m_irq_q[sz-1] : 0;
            exp_v = {m_act == 1, (m_act == 1) ? 4'(8 + m_win) : 4'h0,
                     m_act == 2, (m_act == 2) ? m_ret_q[sz-1] : 8'h00,
                     (m_act == 1) ? 4'(1 << m_win) : 4'h0,
                     sz > 0, 2'(act_i), 3'(sz), sz == 4, m_uf};
            n_tests++;
            if (outs1() !== exp_v) begin
                n_fail++;
                if (shown < 10) $display("FAIL random cycle %0d: got %h, required %h", cyc, outs1(), exp_v);
                shown++;
            end
            for (int i = 0; i < 4; i++) tog[i] = ($urandom_range(0, 7) == 0);
            new_irq     = b1.irq ^ tog;
            b1.irq      = new_irq;
            b1.reti     = ($urandom_range(0, 9) == 0);
            b1.seq_jmp  = ($urandom_range(0, 3) == 0);
            b1.mask_wr  = ($urandom_range(0, 15) == 0);
            b1.mask_in  = 4'($urandom_range(0, 15));
            b1.pc       = 8'($urandom_range(0, 255));
            edges = new_irq & ~m_prev;
            if (m_act == 1) begin
                m_ret_q.push_back(b1.pc + 8'd1);
                m_irq_q.push_back(m_win);
                m_pend = (m_pend | edges) & ~(4'(1 << m_win));
                m_act  = 0;
            end else if (m_act == 2) begin
                void'(m_ret_q.pop_back());
                void'(m_irq_q.pop_back());
                m_pend = m_pend | edges;
                m_act  = 0;
            end else begin
                if (b1.reti) begin
                    if (sz > 0) m_act = 2;
                    else m_uf = 1'b1;
                end else if (!b1.seq_jmp && sz < 4) begin
                    for (int i = 0; i < 4; i++) begin
                        if (m_pend[i] && m_mask[i] && (sz == 0 || i < act_i)) begin
                            m_act = 1;
                            m_win = i;
                            break;
                        end
                    end
                end
                m_pend = m_pend | edges;
            end
            if (b1.mask_wr) m_mask = b1.mask_in;
            m_prev = new_irq;
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        int n;
        do_reset();
        write_mask(0, 4'b0001);
        b1.irq[0] = 1'b1;
        wait_jmp(0, 6, n);
        n_tests++;
        if (n !== 2) begin n_fail++; $display("FAIL areset_setup: got n=%0d, required 2", n); end
        #2;
        sync_reset = 1'b1;
        #1;
        n_tests++;
        if (outs1() !== 26'd0) begin
            n_fail++; $display("FAIL areset_immediate: got %h, required 0", outs1());
        end
        b1.irq = '0;
        repeat (2) tick();
        sync_reset = 1'b0;
        tick();
        n_tests++;
        if (b1.nest_depth !== 3'd0) begin n_fail++; $display("FAIL areset_depth: got %0d, required 0", b1.nest_depth); end
        b1.irq[2] = 1'b1;
        wait_jmp(0, 4, n);
        n_tests++;
        if (n !== -1) begin n_fail++; $display("FAIL areset_mask_cleared: got entry at %0d, required none", n); end
        b1.irq = '0;
        write_mask(0, 4'b0001);
        wait_jmp(0, 4, n);
        n_tests++;
        if (n !== -1) begin n_fail++; $display("FAIL areset_pending_cleared: got entry at %0d, required none", n); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority_nesting();
        test_blocking();
        test_collision_underflow();
        test_stack_full();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
